// File: rtl/cpu6_immgen_pipe.sv
// Registered immediate generator for the cpu6 decode stage: decodes I/S/B/U/J/Z
// immediates, computes pc+imm, and buffers results in a 2-entry skid buffer.
module cpu6_immgen_pipe #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned IMMTYPE_W = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [IMMTYPE_W-1:0] in_immtype,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [XLEN-1:0]      out_target,
    output logic [XLEN-1:0]      out_pc,
    output logic                 out_illegal
);

    typedef enum logic [IMMTYPE_W-1:0] {
        IMM_NONE = IMMTYPE_W'(0),
        IMM_I    = IMMTYPE_W'(1),
        IMM_S    = IMMTYPE_W'(2),
        IMM_B    = IMMTYPE_W'(3),
        IMM_U    = IMMTYPE_W'(4),
        IMM_J    = IMMTYPE_W'(5),
        IMM_Z    = IMMTYPE_W'(6)
    } immtype_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    entry_t m_q, s_q, new_entry;
    logic   m_valid, s_valid;
    logic   in_fire, out_fire;
    logic [XLEN-1:0] imm;
    logic            illegal;

    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (in_immtype)
            IMM_NONE: imm = '0;
            IMM_I:    imm = XLEN'($signed(in_instr[31:20]));
            IMM_S:    imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            IMM_B:    imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                           in_instr[11:8], 1'b0}));
            IMM_U:    imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            IMM_J:    imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                           in_instr[30:21], 1'b0}));
            IMM_Z:    imm = XLEN'(in_instr[19:15]);
            default: begin
                imm     = '0;
                illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        new_entry.imm     = imm;
        new_entry.target  = in_pc + imm;
        new_entry.pc      = in_pc;
        new_entry.illegal = illegal;
    end

    assign in_ready  = !s_valid;
    assign out_valid = m_valid;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = m_valid & out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_q     <= '0;
            s_q     <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (out_fire && s_valid) begin
            // in_ready is low whenever S holds data, so no input competes here
            m_q     <= s_q;
            s_valid <= 1'b0;
        end else if (in_fire && (!m_valid || out_fire)) begin
            m_q     <= new_entry;
            m_valid <= 1'b1;
        end else if (in_fire) begin
            s_q     <= new_entry;
            s_valid <= 1'b1;
        end else if (out_fire) begin
            m_valid <= 1'b0;
        end
    end

    assign out_imm     = m_q.imm;
    assign out_target  = m_q.target;
    assign out_pc      = m_q.pc;
    assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_cpu6_immgen_pipe.sv
// Directed self-checking bench for cpu6_immgen_pipe: XLEN=32 and XLEN=64 instances.
module tb_cpu6_immgen_pipe;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic flush = 1'b0;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_out_illegal;
    logic [31:0] a_in_instr = '0, a_in_pc = '0, a_out_imm, a_out_target, a_out_pc;
    logic [2:0]  a_in_immtype = '0;

    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_illegal;
    logic [31:0] b_in_instr = '0;
    logic [63:0] b_in_pc = '0, b_out_imm, b_out_target, b_out_pc;
    logic [2:0]  b_in_immtype = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu6_immgen_pipe #(.XLEN(32), .IMMTYPE_W(3)) dut32 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr),
        .in_pc(a_in_pc), .in_immtype(a_in_immtype),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
        .out_target(a_out_target), .out_pc(a_out_pc), .out_illegal(a_out_illegal)
    );

    cpu6_immgen_pipe #(.XLEN(64), .IMMTYPE_W(3)) dut64 (
        .clk(clk), .resetn(resetn), .flush(1'b0),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
        .in_pc(b_in_pc), .in_immtype(b_in_immtype),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
        .out_target(b_out_target), .out_pc(b_out_pc), .out_illegal(b_out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [2:0]  t;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        ill;
    } vec_t;

    vec_t t32[9];
    vec_t t64[4];

    initial begin
        t32 = '{
            '{32'hFFF00093, 64'h0,        3'd1, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0},
            '{32'hFE000EE3, 64'h100,      3'd3, 64'hFFFFFFFC, 64'h000000FC, 1'b0},
            '{32'h0010006F, 64'h1000,     3'd5, 64'h800,      64'h1800,     1'b0},
            '{32'hFE112E23, 64'h200,      3'd2, 64'hFFFFFFFC, 64'h1FC,      1'b0},
            '{32'h12345037, 64'h10,       3'd4, 64'h12345000, 64'h12345010, 1'b0},
            '{32'h000F8073, 64'h20,       3'd6, 64'h1F,       64'h3F,       1'b0},
            '{32'hFFFFFFFF, 64'h44,       3'd0, 64'h0,        64'h44,       1'b0},
            '{32'hFFFFFFFF, 64'h8,        3'd7, 64'h0,        64'h8,        1'b1},
            '{32'h7FF00093, 64'hFFFFFFFF, 3'd1, 64'h7FF,      64'h7FE,      1'b0}
        };
        t64 = '{
            '{32'h800000B7, 64'h0,    3'd4, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0},
            '{32'h000F8073, 64'h1000, 3'd6, 64'h1F,               64'h101F,             1'b0},
            '{32'h12345678, 64'h40,   3'd7, 64'h0,                64'h40,               1'b1},
            '{32'hFFF00093, 64'h10,   3'd1, 64'hFFFFFFFFFFFFFFFF, 64'hF,                1'b0}
        };

        // Reset state
        #1 resetn = 1'b0;
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_imm", a_out_imm, 0);
        chk("rst_out_target", a_out_target, 0);
        chk("rst_out_pc", a_out_pc, 0);
        chk("rst_out_illegal", a_out_illegal, 0);
        chk("rst64_out_valid", b_out_valid, 0);
        step();
        resetn = 1'b1;
        step();

        // Back-to-back XLEN=32 decode sweep with out_ready high
        a_out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            a_in_valid = 1'b1;
            a_in_instr = t32[i].instr;
            a_in_pc = t32[i].pc[31:0];
            a_in_immtype = t32[i].t;
            step();
            chk($sformatf("d32_%0d_valid", i), a_out_valid, 1);
            chk($sformatf("d32_%0d_imm", i), a_out_imm, t32[i].imm);
            chk($sformatf("d32_%0d_target", i), a_out_target, t32[i].tgt);
            chk($sformatf("d32_%0d_pc", i), a_out_pc, t32[i].pc);
            chk($sformatf("d32_%0d_illegal", i), a_out_illegal, t32[i].ill);
            chk($sformatf("d32_%0d_in_ready", i), a_in_ready, 1);
        end
        a_in_valid = 1'b0;
        step();
        chk("d32_drain_valid", a_out_valid, 0);

        // XLEN=64 decode
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1;
            b_in_instr = t64[i].instr;
            b_in_pc = t64[i].pc;
            b_in_immtype = t64[i].t;
            step();
            chk($sformatf("d64_%0d_valid", i), b_out_valid, 1);
            chk($sformatf("d64_%0d_imm", i), b_out_imm, t64[i].imm);
            chk($sformatf("d64_%0d_target", i), b_out_target, t64[i].tgt);
            chk($sformatf("d64_%0d_illegal", i), b_out_illegal, t64[i].ill);
        end
        b_in_valid = 1'b0;
        step();
        chk("d64_drain_valid", b_out_valid, 0);

        // Backpressure: A,B accepted, C held off, then drain in order
        a_out_ready = 1'b0;
        a_in_immtype = 3'd1;
        a_in_pc = 32'h0;
        a_in_valid = 1'b1;
        a_in_instr = 32'h00100013;
        step();
        chk("bp_a_valid", a_out_valid, 1);
        chk("bp_a_in_ready", a_in_ready, 1);
        chk("bp_a_imm", a_out_imm, 1);
        a_in_instr = 32'h00200013;
        step();
        chk("bp_b_in_ready", a_in_ready, 0);
        chk("bp_b_imm_hold", a_out_imm, 1);
        a_in_instr = 32'h00300013;
        step();
        chk("bp_c_in_ready", a_in_ready, 0);
        chk("bp_c_imm_hold", a_out_imm, 1);
        chk("bp_c_valid_hold", a_out_valid, 1);
        a_out_ready = 1'b1;
        step();
        chk("bp_out2_valid", a_out_valid, 1);
        chk("bp_out2_imm", a_out_imm, 2);
        chk("bp_out2_in_ready", a_in_ready, 1);
        step();
        chk("bp_out3_valid", a_out_valid, 1);
        chk("bp_out3_imm", a_out_imm, 3);
        a_in_instr = 32'h00400013;
        step();
        chk("bp_out4_valid", a_out_valid, 1);
        chk("bp_out4_imm", a_out_imm, 4);
        a_in_valid = 1'b0;
        step();
        chk("bp_end_valid", a_out_valid, 0);
        chk("bp_end_in_ready", a_in_ready, 1);

        // Flush with M and S full and input pending
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_instr = 32'h00500013;
        step();
        a_in_instr = 32'h00600013;
        step();
        chk("fl_full_in_ready", a_in_ready, 0);
        a_in_instr = 32'h00700013;
        flush = 1'b1;
        step();
        flush = 1'b0;
        a_in_valid = 1'b0;
        chk("fl_out_valid", a_out_valid, 0);
        chk("fl_in_ready", a_in_ready, 1);
        a_out_ready = 1'b1;
        step();
        chk("fl_no_ghost", a_out_valid, 0);

        // Flush discards an input accepted in the same cycle
        a_in_valid = 1'b1;
        a_in_instr = 32'h00800013;
        flush = 1'b1;
        step();
        flush = 1'b0;
        a_in_valid = 1'b0;
        chk("fl2_out_valid", a_out_valid, 0);
        step();
        chk("fl2_no_ghost", a_out_valid, 0);

        // Asynchronous reset mid-transfer with M and S full
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_instr = 32'h00500013;
        a_in_pc = 32'h30;
        step();
        a_in_instr = 32'h00600013;
        step();
        a_in_valid = 1'b0;
        chk("ar_pre_valid", a_out_valid, 1);
        chk("ar_pre_in_ready", a_in_ready, 0);
        #2 resetn = 1'b0;
        #1;
        chk("ar_out_valid", a_out_valid, 0);
        chk("ar_in_ready", a_in_ready, 1);
        chk("ar_out_imm", a_out_imm, 0);
        chk("ar_out_target", a_out_target, 0);
        chk("ar_out_pc", a_out_pc, 0);
        step();
        resetn = 1'b1;
        a_out_ready = 1'b1;
        a_in_valid = 1'b1;
        a_in_instr = 32'h0010006F;
        a_in_pc = 32'h1000;
        a_in_immtype = 3'd5;
        step();
        a_in_valid = 1'b0;
        chk("ar_resume_valid", a_out_valid, 1);
        chk("ar_resume_imm", a_out_imm, 32'h800);
        chk("ar_resume_target", a_out_target, 32'h1800);
        step();
        chk("ar_resume_drain", a_out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
